// File: rtl/mrpnwp_1r1w_phys_resp.sv
// mrpnwp_1r1w_phys_resp
//   Physical-side responder for the multi-read/multi-write-port 1r1w algorithm core.
//   Holds a flop-array backing store, zero-fills it after every reset, then services
//   per-port physical writes and fully pipelined reads with a fixed SRAM_DELAY latency.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   ready          high once the zero-fill sweep has finished
//   pwrite/pwr_adr/pdin   NUMWRPT write ports, port i at slice i
//   pread/prd_adr          NUMRDPT read ports, port j at slice j
//   t1_doutB       read data, valid with vread_vld_bus, held while not valid
//   vread_vld_bus  one-cycle pulse per accepted read, SRAM_DELAY cycles after request
//   vread_padr_bus zero-extended address of the returned word, held while not valid
//
// Build option
//   MRPNWP_RESP_FWD_EN  when defined, a read returns data written to the same address in
//                       the same cycle (highest write port wins); otherwise the old data.

module mrpnwp_1r1w_phys_resp #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUMRDPT    = 2,
  parameter int unsigned NUMWRPT    = 3,
  parameter int unsigned NUMADDR    = 256,
  parameter int unsigned BITADDR    = 8,
  parameter int unsigned BITPADR    = 8,
  parameter int unsigned SRAM_DELAY = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       ready,
  input  logic [NUMWRPT-1:0]         pwrite,
  input  logic [NUMWRPT*BITADDR-1:0] pwr_adr,
  input  logic [NUMWRPT*WIDTH-1:0]   pdin,
  input  logic [NUMRDPT-1:0]         pread,
  input  logic [NUMRDPT*BITADDR-1:0] prd_adr,
  output logic [NUMRDPT*WIDTH-1:0]   t1_doutB,
  output logic [NUMRDPT-1:0]         vread_vld_bus,
  output logic [NUMRDPT*BITPADR-1:0] vread_padr_bus
);

  localparam int unsigned Last = SRAM_DELAY - 1;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e             state_q;
  logic [BITADDR-1:0] init_cnt_q;
  logic               ready_q;

  function automatic logic adr_ok(input logic [BITADDR-1:0] a);
    return 32'(a) < NUMADDR;
  endfunction

  // Unpack the flat port buses.
  logic [BITADDR-1:0] wr_adr  [NUMWRPT];
  logic [WIDTH-1:0]   wr_data [NUMWRPT];
  logic [BITADDR-1:0] rd_adr  [NUMRDPT];

  always_comb begin
    for (int i = 0; i < NUMWRPT; i++) begin
      wr_adr[i]  = pwr_adr[i*BITADDR +: BITADDR];
      wr_data[i] = pdin[i*WIDTH +: WIDTH];
    end
    for (int j = 0; j < NUMRDPT; j++) begin
      rd_adr[j] = prd_adr[j*BITADDR +: BITADDR];
    end
  end

  // Init sweep: one word per cycle, RUN is entered on the edge that clears the last word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        StInit: begin
          if (init_cnt_q == BITADDR'(NUMADDR - 1)) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end else begin
            init_cnt_q <= init_cnt_q + BITADDR'(1);
          end
        end
        StRun: begin
          state_q <= StRun;
        end
      endcase
    end
  end

  // Backing store is not reset; the init sweep is what clears it.
  logic [WIDTH-1:0] mem_q [NUMADDR];

  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      mem_q[init_cnt_q] <= '0;
    end else begin
      // Later iterations override earlier ones, so the highest port index wins.
      for (int i = 0; i < NUMWRPT; i++) begin
        if (pwrite[i] && adr_ok(wr_adr[i])) begin
          mem_q[wr_adr[i]] <= wr_data[i];
        end
      end
    end
  end

  logic [WIDTH-1:0] rd_data [NUMRDPT];

  always_comb begin
    for (int j = 0; j < NUMRDPT; j++) begin
      rd_data[j] = adr_ok(rd_adr[j]) ? mem_q[rd_adr[j]] : '0;
`ifdef MRPNWP_RESP_FWD_EN
      for (int i = 0; i < NUMWRPT; i++) begin
        if (pwrite[i] && adr_ok(wr_adr[i]) && (wr_adr[i] == rd_adr[j])) begin
          rd_data[j] = wr_data[i];
        end
      end
`endif
    end
  end

  // Read pipeline: stage 0 captures the lookup, stage Last drives the outputs.
  logic [SRAM_DELAY-1:0][NUMRDPT-1:0]         vld_q, vld_d;
  logic [SRAM_DELAY-1:0][NUMRDPT*WIDTH-1:0]   data_q, data_d;
  logic [SRAM_DELAY-1:0][NUMRDPT*BITPADR-1:0] padr_q, padr_d;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    padr_d = padr_q;
    vld_d[0] = pread & {NUMRDPT{ready_q}};
    for (int j = 0; j < NUMRDPT; j++) begin
      data_d[0][j*WIDTH +: WIDTH]     = rd_data[j];
      padr_d[0][j*BITPADR +: BITPADR] = BITPADR'(rd_adr[j]);
    end
    for (int s = 1; s < SRAM_DELAY; s++) begin
      vld_d[s]  = vld_q[s-1];
      data_d[s] = data_q[s-1];
      padr_d[s] = padr_q[s-1];
    end
    // Output stage only loads on a valid beat so data/padr hold between pulses.
    for (int j = 0; j < NUMRDPT; j++) begin
      if (!vld_d[Last][j]) begin
        data_d[Last][j*WIDTH +: WIDTH]     = data_q[Last][j*WIDTH +: WIDTH];
        padr_d[Last][j*BITPADR +: BITPADR] = padr_q[Last][j*BITPADR +: BITPADR];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= '0;
      data_q <= '0;
      padr_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      padr_q <= padr_d;
    end
  end

  assign ready          = ready_q;
  assign vread_vld_bus  = vld_q[Last];
  assign t1_doutB       = data_q[Last];
  assign vread_padr_bus = padr_q[Last];

endmodule

// File: tb/tb_mrpnwp_1r1w_phys_resp.sv
module tb_mrpnwp_1r1w_phys_resp;
  localparam int unsigned W = 32, NRD = 2, NWR = 3, NA = 256, BA = 8, BP = 8, DLY = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ready;
  logic [NWR-1:0]    pwrite;
  logic [NWR*BA-1:0] pwr_adr;
  logic [NWR*W-1:0]  pdin;
  logic [NRD-1:0]    pread;
  logic [NRD*BA-1:0] prd_adr;
  logic [NRD*W-1:0]  t1_doutB;
  logic [NRD-1:0]    vread_vld_bus;
  logic [NRD*BP-1:0] vread_padr_bus;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mrpnwp_1r1w_phys_resp #(
    .WIDTH(W), .NUMRDPT(NRD), .NUMWRPT(NWR), .NUMADDR(NA),
    .BITADDR(BA), .BITPADR(BP), .SRAM_DELAY(DLY)
  ) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .pwrite(pwrite), .pwr_adr(pwr_adr), .pdin(pdin),
    .pread(pread), .prd_adr(prd_adr),
    .t1_doutB(t1_doutB), .vread_vld_bus(vread_vld_bus), .vread_padr_bus(vread_padr_bus)
  );

  // Reference model: word array plus a per-port list of reads due at a given cycle.
  typedef struct packed {
    int unsigned    due;
    logic [W-1:0]   d;
    logic [BA-1:0]  a;
  } rd_t;

  rd_t          pend [NRD][$];
  logic [W-1:0] mdl_mem [NA];
  int unsigned  cyc = 0;
  int unsigned  init_cnt = 0;
  bit           mdl_ready = 1'b0;
  bit           rst_at_edge = 1'b0;
  logic [NRD-1:0] exp_vld;
  logic [W-1:0]   exp_data [NRD];
  logic [BP-1:0]  exp_padr [NRD];

  function automatic logic [W-1:0] dout(input int j);
    return t1_doutB[j*W +: W];
  endfunction

  function automatic logic [BP-1:0] padr(input int j);
    return vread_padr_bus[j*BP +: BP];
  endfunction

  task automatic idle();
    pwrite = '0; pwr_adr = '0; pdin = '0; pread = '0; prd_adr = '0;
  endtask

  task automatic set_wr(input int i, input logic [BA-1:0] a, input logic [W-1:0] d);
    pwrite[i] = 1'b1;
    pwr_adr[i*BA +: BA] = a;
    pdin[i*W +: W] = d;
  endtask

  task automatic set_rd(input int j, input logic [BA-1:0] a);
    pread[j] = 1'b1;
    prd_adr[j*BA +: BA] = a;
  endtask

  // Advance one clock: apply this cycle's inputs to the model, then update expectations.
  task automatic tick();
    if (rst && mdl_ready) begin
      for (int j = 0; j < NRD; j++) begin
        if (pread[j]) begin
          rd_t e;
          e.a = prd_adr[j*BA +: BA];
          e.d = (32'(e.a) < NA) ? mdl_mem[e.a] : '0;
`ifdef MRPNWP_RESP_FWD_EN
          for (int i = 0; i < NWR; i++) begin
            if (pwrite[i] && pwr_adr[i*BA +: BA] == e.a && 32'(e.a) < NA) e.d = pdin[i*W +: W];
          end
`endif
          e.due = cyc + DLY;
          pend[j].push_back(e);
        end
      end
      for (int i = 0; i < NWR; i++) begin
        if (pwrite[i] && 32'(pwr_adr[i*BA +: BA]) < NA) mdl_mem[pwr_adr[i*BA +: BA]] = pdin[i*W +: W];
      end
    end
    @(posedge clk);
    if (rst_at_edge) begin
      rst = 1'b0;
      rst_at_edge = 1'b0;
    end
    #1;
    cyc++;
    if (!rst) begin
      init_cnt = 0;
      mdl_ready = 1'b0;
      exp_vld = '0;
      for (int j = 0; j < NRD; j++) begin
        pend[j].delete();
        exp_data[j] = '0;
        exp_padr[j] = '0;
      end
    end else begin
      if (init_cnt < NA) begin
        init_cnt++;
        if (init_cnt == NA) begin
          for (int k = 0; k < NA; k++) mdl_mem[k] = '0;
        end
      end
      mdl_ready = (init_cnt == NA);
      for (int j = 0; j < NRD; j++) begin
        exp_vld[j] = 1'b0;
        if (pend[j].size() > 0 && pend[j][0].due == cyc) begin
          rd_t e = pend[j].pop_front();
          exp_vld[j]  = 1'b1;
          exp_data[j] = e.d;
          exp_padr[j] = BP'(e.a);
        end
      end
    end
  endtask

  task automatic test_reset();
    idle();
    #2 rst = 1'b0;
    tick();
    tick();
    checks++;
    if (ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready: got %b want 0", ready);
    end
    checks++;
    if (vread_vld_bus !== '0) begin
      failures++; $display("FAIL reset_vld: got %b want 0", vread_vld_bus);
    end
    checks++;
    if (t1_doutB !== '0) begin
      failures++; $display("FAIL reset_dout: got %h want 0", t1_doutB);
    end
    checks++;
    if (vread_padr_bus !== '0) begin
      failures++; $display("FAIL reset_padr: got %h want 0", vread_padr_bus);
    end
    rst = 1'b1;
    // Reads issued during init must be ignored.
    set_rd(0, 8'd3);
    for (int n = 0; n < 300 && !mdl_ready; n++) begin
      tick();
      checks++;
      if (ready !== mdl_ready || vread_vld_bus !== '0) begin
        failures++;
        $display("FAIL init_ready cyc%0d: got ready=%b vld=%b want ready=%b vld=0",
                 n + 1, ready, vread_vld_bus, mdl_ready);
      end
    end
    idle();
    checks++;
    if (!mdl_ready || ready !== 1'b1) begin
      failures++; $display("FAIL init_done: got ready=%b want 1", ready);
    end
  endtask

  task automatic test_init_reads();
    for (int k = 0; k < 5; k++) begin
      idle();
      if (k == 0) begin set_rd(0, 8'd0); set_rd(1, 8'd17); end
      if (k == 1) set_rd(0, 8'd255);
      tick();
      for (int j = 0; j < NRD; j++) begin
        checks++;
        if (vread_vld_bus[j] !== exp_vld[j] || dout(j) !== exp_data[j] || padr(j) !== exp_padr[j]
            || (exp_vld[j] && dout(j) !== 32'h0)) begin
          failures++;
          $display("FAIL init_reads p%0d k%0d: got vld=%b d=%h a=%h want vld=%b d=%h a=%h",
                   j, k, vread_vld_bus[j], dout(j), padr(j), exp_vld[j], exp_data[j], exp_padr[j]);
        end
      end
    end
  endtask

  task automatic test_write_read();
    for (int k = 0; k < 4; k++) begin
      idle();
      if (k == 0) set_wr(1, 8'd5, 32'hDEADBEEF);
      if (k == 1) set_rd(0, 8'd5);
      tick();
      for (int j = 0; j < NRD; j++) begin
        checks++;
        if (vread_vld_bus[j] !== exp_vld[j] || dout(j) !== exp_data[j] || padr(j) !== exp_padr[j]) begin
          failures++;
          $display("FAIL write_read p%0d k%0d: got vld=%b d=%h a=%h want vld=%b d=%h a=%h",
                   j, k, vread_vld_bus[j], dout(j), padr(j), exp_vld[j], exp_data[j], exp_padr[j]);
        end
      end
      if (k == 2) begin
        checks++;
        if (vread_vld_bus[0] !== 1'b1 || dout(0) !== 32'hDEADBEEF || padr(0) !== 8'd5) begin
          failures++;
          $display("FAIL write_read_t3: got vld=%b d=%h a=%h want vld=1 d=deadbeef a=05",
                   vread_vld_bus[0], dout(0), padr(0));
        end
      end
    end
  endtask

  task automatic test_write_conflict();
    for (int k = 0; k < 4; k++) begin
      idle();
      if (k == 0) begin
        set_wr(0, 8'd9, 32'h1); set_wr(1, 8'd9, 32'h2); set_wr(2, 8'd9, 32'h3);
      end
      if (k == 1) set_rd(1, 8'd9);
      tick();
      for (int j = 0; j < NRD; j++) begin
        checks++;
        if (vread_vld_bus[j] !== exp_vld[j] || dout(j) !== exp_data[j] || padr(j) !== exp_padr[j]) begin
          failures++;
          $display("FAIL write_conflict p%0d k%0d: got vld=%b d=%h want vld=%b d=%h",
                   j, k, vread_vld_bus[j], dout(j), exp_vld[j], exp_data[j]);
        end
      end
      if (k == 2) begin
        checks++;
        if (vread_vld_bus[1] !== 1'b1 || dout(1) !== 32'h3) begin
          failures++;
          $display("FAIL write_conflict_wins: got vld=%b d=%h want vld=1 d=00000003",
                   vread_vld_bus[1], dout(1));
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [W-1:0] want;
`ifdef MRPNWP_RESP_FWD_EN
    want = 32'hA5A5A5A5;
`else
    want = 32'h0;
`endif
    for (int k = 0; k < 3; k++) begin
      idle();
      if (k == 0) begin set_wr(0, 8'd12, 32'hA5A5A5A5); set_rd(0, 8'd12); end
      tick();
      for (int j = 0; j < NRD; j++) begin
        checks++;
        if (vread_vld_bus[j] !== exp_vld[j] || dout(j) !== exp_data[j] || padr(j) !== exp_padr[j]) begin
          failures++;
          $display("FAIL same_cycle p%0d k%0d: got vld=%b d=%h want vld=%b d=%h",
                   j, k, vread_vld_bus[j], dout(j), exp_vld[j], exp_data[j]);
        end
      end
      if (k == 1) begin
        checks++;
        if (vread_vld_bus[0] !== 1'b1 || dout(0) !== want || padr(0) !== 8'd12) begin
          failures++;
          $display("FAIL same_cycle_rbw: got vld=%b d=%h a=%h want vld=1 d=%h a=0c",
                   vread_vld_bus[0], dout(0), padr(0), want);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses [NRD];
    for (int j = 0; j < NRD; j++) pulses[j] = 0;
    for (int k = 0; k < 50 + DLY; k++) begin
      idle();
      if (k < 50) begin
        for (int j = 0; j < NRD; j++) set_rd(j, 8'($urandom_range(0, 31)));
        for (int i = 0; i < NWR; i++) begin
          if ($urandom_range(0, 1) == 1) set_wr(i, 8'($urandom_range(0, 31)), $urandom);
        end
      end
      tick();
      for (int j = 0; j < NRD; j++) begin
        if (vread_vld_bus[j] === 1'b1) pulses[j]++;
        checks++;
        if (vread_vld_bus[j] !== exp_vld[j] || dout(j) !== exp_data[j] || padr(j) !== exp_padr[j]) begin
          failures++;
          $display("FAIL back_to_back p%0d k%0d: got vld=%b d=%h a=%h want vld=%b d=%h a=%h",
                   j, k, vread_vld_bus[j], dout(j), padr(j), exp_vld[j], exp_data[j], exp_padr[j]);
        end
      end
    end
    for (int j = 0; j < NRD; j++) begin
      checks++;
      if (pulses[j] != 50) begin
        failures++;
        $display("FAIL back_to_back_count p%0d: got %0d pulses want 50", j, pulses[j]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    idle();
    set_rd(0, 8'd5); set_rd(1, 8'd9);
    tick();
    idle();
    set_rd(0, 8'd9); set_rd(1, 8'd5);
    rst_at_edge = 1'b1;
    tick();
    idle();
    tick();
    rst = 1'b1;
    for (int n = 0; n < 300 && !mdl_ready; n++) begin
      tick();
      checks++;
      if (ready !== mdl_ready || vread_vld_bus !== '0) begin
        failures++;
        $display("FAIL midreset_reinit cyc%0d: got ready=%b vld=%b want ready=%b vld=0",
                 n + 1, ready, vread_vld_bus, mdl_ready);
      end
    end
    checks++;
    if (!mdl_ready || ready !== 1'b1) begin
      failures++; $display("FAIL midreset_ready: got ready=%b want 1", ready);
    end
    for (int k = 0; k < 3; k++) begin
      idle();
      if (k == 0) set_rd(0, 8'd9);
      tick();
      checks++;
      if (vread_vld_bus[0] !== exp_vld[0] || dout(0) !== exp_data[0]
          || (k == 1 && (vread_vld_bus[0] !== 1'b1 || dout(0) !== 32'h0))) begin
        failures++;
        $display("FAIL midreset_cleared k%0d: got vld=%b d=%h want vld=%b d=%h",
                 k, vread_vld_bus[0], dout(0), exp_vld[0], exp_data[0]);
      end
    end
  endtask

  initial begin
    idle();
    exp_vld = '0;
    for (int j = 0; j < NRD; j++) begin
      exp_data[j] = '0;
      exp_padr[j] = '0;
    end
    test_reset();
    test_init_reads();
    test_write_read();
    test_write_conflict();
    test_same_cycle();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
